// File: rtl/edp_muldiv_seq.sv
// Purpose : microsequencer stepping the EDP control fields through multiply (shift-and-add) and divide (non-restoring).
// Latency : start -> done is STEPS+2 cycles (multiply), STEPS+3 (divide), 2 (divide overflow abort).
// Backpressure: none; start is sampled only in IDLE and dropped otherwise, no queuing.
//
// Ports: clk/rstN (async active-low); start/isDiv request; mq35, ad0, adOverflow status from the EDP;
//        busy/done/divOvf/qBit status; ADsel..MQMsel are the EDP control fields owned while busy.
// Optional: EDP_MULDIV_EARLY_TERM_EN adds input mqZero, which ends a multiply after the current step.
module edp_muldiv_seq #(
    parameter int STEPS = 36,
    parameter int CNTW  = 6
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic       start,
    input  logic       isDiv,
    input  logic       mq35,
    input  logic       ad0,
    input  logic       adOverflow,
`ifdef EDP_MULDIV_EARLY_TERM_EN
    input  logic       mqZero,
`endif
    output logic       busy,
    output logic       done,
    output logic       divOvf,
    output logic       qBit,
    output logic [3:0] ADsel,
    output logic       ADbool,
    output logic       adCin,
    output logic [1:0] ADAsel,
    output logic [1:0] ADBsel,
    output logic [2:0] ARLsel,
    output logic [2:0] ARRsel,
    output logic       ARload,
    output logic       ARXload,
    output logic [2:0] ARXLsel,
    output logic [2:0] ARXRsel,
    output logic [1:0] MQsel,
    output logic       MQMen,
    output logic [1:0] MQMsel
);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STEP, S_FIXUP, S_DONE} state_t;

    // Control fields that depend only on the sequencer state; registered from next state.
    typedef struct packed {
        logic       busy;
        logic       done;
        logic [1:0] ada_sel;
        logic [1:0] adb_sel;
        logic [2:0] arl_sel;
        logic [2:0] arr_sel;
        logic       ar_load;
        logic       arx_load;
        logic [2:0] arxl_sel;
        logic [2:0] arxr_sel;
        logic [1:0] mq_sel;
        logic       mqm_en;
        logic [1:0] mqm_sel;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{mq_sel: 2'b11, default: '0};

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            div_q, div_d;
    logic            sub_q, sub_d;   // next divide step subtracts (previous AD was non-negative)
    logic            ovf_q, ovf_d;
    ctrl_t           ctrl_q, ctrl_d;
    logic            fix_load;
    logic            step_exit;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            sub_q   <= 1'b0;
            ovf_q   <= 1'b0;
            ctrl_q  <= CTRL_IDLE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            sub_q   <= sub_d;
            ovf_q   <= ovf_d;
            ctrl_q  <= ctrl_d;
        end
    end

    always_comb begin
        step_exit = (cnt_q == '0);
`ifdef EDP_MULDIV_EARLY_TERM_EN
        if (!div_q && mqZero) begin
            step_exit = 1'b1;
        end
`endif
    end

    // Next state and sequencing context.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        sub_d   = sub_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SETUP;
                    div_d   = isDiv;
                    ovf_d   = 1'b0;
                end
            end
            S_SETUP: begin
                cnt_d = CNTW'(STEPS - 1);
                sub_d = 1'b1;   // first divide step is always A-B
                if (div_q && adOverflow) begin
                    ovf_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                if (div_q) begin
                    sub_d = ~ad0;
                end
                if (step_exit) begin
                    cnt_d   = '0;
                    state_d = div_q ? S_FIXUP : S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_FIXUP: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State-only control fields, decoded from the next state so they are flop outputs.
    always_comb begin
        ctrl_d = CTRL_IDLE;
        case (state_d)
            S_SETUP: ctrl_d.busy = 1'b1;
            S_STEP: begin
                ctrl_d.busy     = 1'b1;
                ctrl_d.adb_sel  = 2'b10;   // B input is BR for both add and subtract
                ctrl_d.ar_load  = 1'b1;
                ctrl_d.arx_load = 1'b1;
                if (div_d) begin
                    ctrl_d.arl_sel  = 3'b101;
                    ctrl_d.arr_sel  = 3'b101;
                    ctrl_d.arxl_sel = 3'b101;
                    ctrl_d.arxr_sel = 3'b101;
                    ctrl_d.mq_sel   = 2'b01;
                end else begin
                    ctrl_d.arl_sel  = 3'b111;
                    ctrl_d.arr_sel  = 3'b111;
                    ctrl_d.arxl_sel = 3'b111;
                    ctrl_d.arxr_sel = 3'b111;
                    ctrl_d.mq_sel   = 2'b00;
                    ctrl_d.mqm_en   = 1'b1;
                    ctrl_d.mqm_sel  = 2'b00;
                end
            end
            S_FIXUP: ctrl_d.busy = 1'b1;
            S_DONE:  ctrl_d.done = 1'b1;
            default: ;
        endcase
    end

    // AD function and quotient bit follow mq35/ad0 within the cycle.
    always_comb begin
        ADsel    = 4'b0000;
        ADbool   = 1'b0;
        adCin    = 1'b0;
        qBit     = 1'b0;
        fix_load = 1'b0;
        case (state_q)
            S_SETUP: begin
                ADsel  = 4'b1111;
                ADbool = 1'b1;
            end
            S_STEP: begin
                if (div_q) begin
                    qBit = ~ad0;
                    if (sub_q) begin
                        ADsel = 4'b1001;
                        adCin = 1'b1;
                    end else begin
                        ADsel = 4'b0110;
                    end
                end else if (mq35) begin
                    ADsel = 4'b0110;
                end else begin
                    ADsel  = 4'b1111;
                    ADbool = 1'b1;
                end
            end
            S_FIXUP: begin
                // Negative final remainder: add the divisor back.
                if (ad0) begin
                    ADsel    = 4'b0110;
                    fix_load = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign busy    = ctrl_q.busy;
    assign done    = ctrl_q.done;
    assign divOvf  = ovf_q;
    assign ADAsel  = ctrl_q.ada_sel;
    assign ADBsel  = ctrl_q.adb_sel;
    assign ARLsel  = ctrl_q.arl_sel;
    assign ARRsel  = ctrl_q.arr_sel;
    assign ARload  = ctrl_q.ar_load | fix_load;
    assign ARXload = ctrl_q.arx_load;
    assign ARXLsel = ctrl_q.arxl_sel;
    assign ARXRsel = ctrl_q.arxr_sel;
    assign MQsel   = ctrl_q.mq_sel;
    assign MQMen   = ctrl_q.mqm_en;
    assign MQMsel  = ctrl_q.mqm_sel;

endmodule

// File: tb/tb_edp_muldiv_seq.sv
// Purpose : self-checking bench for edp_muldiv_seq; table of operations plus reset/abort sequences.
// Latency : expected done cycle per operation is held in a scoreboard queue.
// Backpressure: n/a.
module tb_edp_muldiv_seq;
    localparam int STEPS = 36;
    localparam int CNTW  = 6;

    logic       clk = 1'b0;
    logic       rstN, start, isDiv, mq35, ad0, adOverflow;
    logic       busy, done, divOvf, qBit, ADbool, adCin, ARload, ARXload, MQMen;
    logic [3:0] ADsel;
    logic [1:0] ADAsel, ADBsel, MQsel, MQMsel;
    logic [2:0] ARLsel, ARRsel, ARXLsel, ARXRsel;
`ifdef EDP_MULDIV_EARLY_TERM_EN
    logic       mqZero = 1'b0;
`endif

    always #5 clk = ~clk;

    edp_muldiv_seq #(.STEPS(STEPS), .CNTW(CNTW)) dut (
        .clk(clk), .rstN(rstN), .start(start), .isDiv(isDiv), .mq35(mq35), .ad0(ad0),
        .adOverflow(adOverflow),
`ifdef EDP_MULDIV_EARLY_TERM_EN
        .mqZero(mqZero),
`endif
        .busy(busy), .done(done), .divOvf(divOvf), .qBit(qBit), .ADsel(ADsel), .ADbool(ADbool),
        .adCin(adCin), .ADAsel(ADAsel), .ADBsel(ADBsel), .ARLsel(ARLsel), .ARRsel(ARRsel),
        .ARload(ARload), .ARXload(ARXload), .ARXLsel(ARXLsel), .ARXRsel(ARXRsel), .MQsel(MQsel),
        .MQMen(MQMen), .MQMsel(MQMsel)
    );

    typedef struct packed {
        logic       busy, done, div_ovf, q_bit;
        logic [3:0] ad_sel;
        logic       ad_bool, ad_cin;
        logic [1:0] ada_sel, adb_sel;
        logic [2:0] arl_sel, arr_sel;
        logic       ar_load, arx_load;
        logic [2:0] arxl_sel, arxr_sel;
        logic [1:0] mq_sel;
        logic       mqm_en;
        logic [1:0] mqm_sel;
    } ctl_t;

    ctl_t act;
    assign act = {busy, done, divOvf, qBit, ADsel, ADbool, adCin, ADAsel, ADBsel, ARLsel, ARRsel,
                  ARload, ARXload, ARXLsel, ARXRsel, MQsel, MQMen, MQMsel};

    typedef struct {
        string name;
        logic  is_div;
        logic  ovf_in;    // adOverflow driven during SETUP
        int    mq_pat;    // 0 alternating 1/0, 1 all ones, 2 all zeros
        int    ad_pat;    // 0 repeating 0,1,1,0, 1 all zeros, 2 all ones
        logic  fix_ad0;   // ad0 during FIXUP
        int    busy_k;    // cycle at which a stray start is pulsed (0 = none)
        int    lat;       // expected done cycle after the accepting edge
        logic  exp_ovf;   // expected divOvf after the operation
    } vec_t;

    typedef struct { int lat; logic ovf; } sb_t;

    localparam int P_IDLE = 0, P_SETUP = 1, P_STEP = 2, P_FIX = 3, P_DONE = 4;

    vec_t vecs[8];
    sb_t  sbq[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, a, e, $time);
        end
    endtask

    function automatic ctl_t idle_ctl(input logic ovf);
        ctl_t e = '0;
        e.mq_sel  = 2'b11;
        e.div_ovf = ovf;
        return e;
    endfunction

    function automatic logic mq_bit(input int pat, input int s);
        if (pat == 0) return (s % 2 == 0);
        if (pat == 1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic ad_bit(input int pat, input int s);
        if (pat == 0) return (s % 4 == 1) || (s % 4 == 2);
        if (pat == 1) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_vec(input vec_t v);
        ctl_t e;
        int   ph, ndone;
        logic sub, m, a;
        sb_t  sb;
        @(negedge clk);
        start = 1'b1; isDiv = v.is_div; adOverflow = 1'b0;
        sbq.push_back('{v.lat, v.exp_ovf});
        @(posedge clk);
        sub = 1'b1;
        ndone = 0;
        for (int k = 1; k <= v.lat + 3; k++) begin
            @(negedge clk);
            start = (k == v.busy_k);
            isDiv = 1'($urandom_range(0, 1));
            adOverflow = (k == 1) ? v.ovf_in : 1'b1;
            if (k == 1) ph = P_SETUP;
            else if (v.exp_ovf) ph = (k == 2) ? P_DONE : P_IDLE;
            else if (k <= STEPS + 1) ph = P_STEP;
            else if (k == STEPS + 2) ph = v.is_div ? P_FIX : P_DONE;
            else if (k == STEPS + 3 && v.is_div) ph = P_DONE;
            else ph = P_IDLE;
            m = mq_bit(v.mq_pat, k - 2);
            a = (ph == P_FIX) ? v.fix_ad0 : ad_bit(v.ad_pat, k - 2);
            if (ph != P_STEP && ph != P_FIX) begin
                m = 1'($urandom_range(0, 1));
                a = 1'($urandom_range(0, 1));
            end
            mq35 = m; ad0 = a;
            e = idle_ctl((k >= 2) ? v.exp_ovf : 1'b0);
            case (ph)
                P_SETUP: begin e.busy = 1'b1; e.ad_sel = 4'b1111; e.ad_bool = 1'b1; end
                P_STEP: begin
                    e.busy = 1'b1; e.adb_sel = 2'b10; e.ar_load = 1'b1; e.arx_load = 1'b1;
                    if (!v.is_div) begin
                        e.ad_sel = m ? 4'b0110 : 4'b1111; e.ad_bool = ~m;
                        e.arl_sel = 3'b111; e.arr_sel = 3'b111; e.arxl_sel = 3'b111; e.arxr_sel = 3'b111;
                        e.mq_sel = 2'b00; e.mqm_en = 1'b1;
                    end else begin
                        e.ad_sel = sub ? 4'b1001 : 4'b0110; e.ad_cin = sub; e.q_bit = ~a;
                        e.arl_sel = 3'b101; e.arr_sel = 3'b101; e.arxl_sel = 3'b101; e.arxr_sel = 3'b101;
                        e.mq_sel = 2'b01;
                    end
                end
                P_FIX: begin
                    e.busy = 1'b1;
                    if (a) begin e.ad_sel = 4'b0110; e.ar_load = 1'b1; end
                end
                P_DONE: e.done = 1'b1;
                default: ;
            endcase
            #1;
            chk($sformatf("%s ctl k=%0d", v.name, k), 64'(act), 64'(e));
            if (ph == P_STEP && v.is_div) sub = ~a;
            if (done) begin
                ndone++;
                if (ndone == 1 && sbq.size() > 0) begin
                    sb = sbq.pop_front();
                    chk({v.name, " latency"}, 64'(k), 64'(sb.lat));
                    chk({v.name, " divOvf"}, 64'(divOvf), 64'(sb.ovf));
                end
            end
        end
        start = 1'b0;
        if (ndone == 0 && sbq.size() > 0) sb = sbq.pop_front();
        chk({v.name, " done_count"}, 64'(ndone), 64'd1);
    endtask

    // Reset asserted mid-multiply (counter = 17): outputs return to reset values at once, no done.
    task automatic reset_mid_step();
        int nd = 0;
        @(negedge clk);
        start = 1'b1; isDiv = 1'b0;
        @(posedge clk);
        for (int k = 1; k < 20; k++) begin
            @(negedge clk);
            start = 1'b0; mq35 = 1'b1;
        end
        @(negedge clk);
        #1 chk("pre_reset busy", 64'(busy), 64'd1);
        rstN = 1'b0;
        #1 chk("async_reset ctl", 64'(act), 64'(idle_ctl(1'b0)));
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            #1 if (done) nd++;
        end
        chk("no_done_after_reset", 64'(nd), 64'd0);
        chk("idle_after_reset ctl", 64'(act), 64'(idle_ctl(1'b0)));
    endtask

    initial begin
        rstN = 1'b1; start = 1'b0; isDiv = 1'b0; mq35 = 1'b0; ad0 = 1'b0; adOverflow = 1'b0;
        vecs[0] = '{"mul_alt",         1'b0, 1'b0, 0, 0, 1'b0, 0, STEPS + 2, 1'b0};
        vecs[1] = '{"mul_ones_ovfin",  1'b0, 1'b1, 1, 0, 1'b0, 0, STEPS + 2, 1'b0};
        vecs[2] = '{"mul_zero_stray",  1'b0, 1'b0, 2, 0, 1'b0, 5, STEPS + 2, 1'b0};
        vecs[3] = '{"div_0110_fix1",   1'b1, 1'b0, 0, 0, 1'b1, 0, STEPS + 3, 1'b0};
        vecs[4] = '{"div_zero_stray",  1'b1, 1'b0, 0, 1, 1'b0, 5, STEPS + 3, 1'b0};
        vecs[5] = '{"div_abort",       1'b1, 1'b1, 0, 0, 1'b0, 0, 2,         1'b1};
        vecs[6] = '{"mul_after_abort", 1'b0, 1'b0, 0, 0, 1'b0, 0, STEPS + 2, 1'b0};
        vecs[7] = '{"div_ones_fix1",   1'b1, 1'b0, 0, 2, 1'b1, 0, STEPS + 3, 1'b0};
        #2 rstN = 1'b0;
        repeat (2) @(negedge clk);
        #1 chk("reset ctl", 64'(act), 64'(idle_ctl(1'b0)));
        rstN = 1'b1;
        for (int i = 0; i < 8; i++) run_vec(vecs[i]);
        reset_mid_step();
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
